id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

Operand-fetch pipeline stage between decode and execute of the RV32I core. It drives the register file read addresses and receives the read data. It resolves RAW hazards by forwarding from MEM and WB, or by stalling, then registers the operands and control into a valid/ready ID/EX pipeline register. WB forwarding is mandatory because the register file writes synchronously: a same-cycle combinational read returns the old value.

## Interface
- XLEN, 32, datapath width
- CTRL_W, 16, width of opaque execute-control bundle passed through unmodified
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid / in_ready  in / out  1 / 1  decode-side handshake
- in_pc, in_imm  in  XLEN  PC and decoded immediate
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_use_rs1, in_use_rs2  in  1  instruction actually reads rs1 / rs2
- in_reg_write, in_mem_read  in  1  writes rd / is a load
- in_ctrl  in  CTRL_W  execute control
- rf_rs1, rf_rs2  out  5  register file read addresses (= in_rs1 / in_rs2, combinational)
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data (x0 reads 0)
- mem_rd, mem_we, mem_data_ok, mem_data  in  5,1,1,XLEN  MEM-stage writer; mem_data_ok=0 means the value is not yet available (load)
- wb_rd, wb_we, wb_data  in  5,1,XLEN  WB writer (same signals as register file write port)
- flush  in  1  kill the instruction in this stage and the one offered
- out_valid / out_ready  out / in  1 / 1  execute-side handshake
- out_pc, out_imm, out_rs1_val, out_rs2_val  out  XLEN  registered operands
- out_rd, out_reg_write, out_mem_read, out_ctrl  out  5,1,1,CTRL_W  registered control

## Operation
- Operand select per source s in {rs1, rs2}, highest priority first:
  - s==0 gives 0.
  - mem_we && mem_rd==s && mem_data_ok gives mem_data.
  - wb_we && wb_rd==s gives wb_data.
  - Otherwise rf data.
- hazard=1 when in_valid and, for any used source s!=0, either condition holds:
  - out_valid && out_mem_read && out_rd==s (load-use, EX).
  - mem_we && mem_rd==s && !mem_data_ok.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Transfer (in_valid && in_ready): all out_* capture the selected operands and in_* fields; out_valid <= 1.
- Drain (out_valid && out_ready, no transfer): out_valid <= 0, producing a bubble. Data fields may hold their last value.
- Hold (out_valid && !out_ready): every out_* stays bit-stable regardless of forwarding inputs.
- flush: out_valid <= 0 next cycle; no transfer in the flush cycle. Flush overrides hold and transfer.
- in_rd==0 with in_reg_write=1: passed through as-is. Downstream and the register file ignore x0 writes.

## Timing
- Latency: 1 cycle, in_valid/in_ready handshake to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1 and no hazard.
- Forward muxes, hazard and in_ready are combinational in the offer cycle. rf_rs* have no register.
- Load-use with load in EX, mem_data_ok=0 in MEM, data in WB: exactly 2 stall cycles, then the WB forward.
- Reset (rst=1 at posedge): out_valid=0 and all out_* = 0. in_ready=0 while rst=1.
- Reset asserted mid-hold discards the held instruction.

## Configuration
- OPERAND_FWD_EN defined: forwarding as above.
- OPERAND_FWD_EN undefined: operand = rf data (0 for x0), with no MEM or WB forward. hazard is also raised for any used s!=0 matching:
  - out_valid && out_reg_write && out_rd==s
  - mem_we && mem_rd==s
  - wb_we && wb_rd==s
- mem_data_ok is ignored when OPERAND_FWD_EN is undefined.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, in_ready=0, all out_*=0. First transfer occurs in the cycle after rst drops.
- WB bypass: rf_rs1_data=0x11, wb_we=1, wb_rd=5=in_rs1, wb_data=0xDEADBEEF → out_rs1_val=0xDEADBEEF. With in_rs1=0 and wb_rd=0, out_rs1_val=0.
- Priority: mem and wb both target x7 (mem_data=0xA, mem_data_ok=1, wb_data=0xB) → out_rs2_val=0xA.
- Load-use: lw x3 transferred, then add reading x3 offered → 2 cycles in_ready=0 with bubbles out. Add then captures wb_data=0x1234.
- Backpressure and flush: out_ready=0 for 3 cycles while wb_data toggles → out_* stable and in_ready=0. Flush in cycle 2 → out_valid=0 next cycle.
- OPERAND_FWD_EN undefined: back-to-back dependent add x1, then add using x1 → in_ready=0 for 3 cycles. Operand then equals rf_rs1_data.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: operand-fetch stage between decode and execute.
// Drives register file read addresses, selects operands (register file, or
// MEM/WB bypass), detects RAW hazards that need a stall, and registers the
// operands plus control into a valid/ready ID/EX pipeline register.
//
// Build option: define OPERAND_FWD_EN to enable MEM/WB forwarding. Without it
// operands come straight from the register file and every in-flight writer of
// a used source register stalls the offered instruction.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,

  // decode-side handshake and instruction fields
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [CTRL_W-1:0] in_ctrl,

  // register file read port
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,

  // MEM-stage writer
  input  logic [4:0]        mem_rd,
  input  logic              mem_we,
  input  logic              mem_data_ok,
  input  logic [XLEN-1:0]   mem_data,

  // WB writer (same as register file write port)
  input  logic [4:0]        wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,

  input  logic              flush,

  // execute-side handshake and registered operands/control
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_conflict;
  logic            rs2_conflict;
  logic            hazard;
  logic            downstream_free;
  logic            xfer;

  // Register file addresses are the decoded indices, unregistered.
  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

`ifndef OPERAND_FWD_EN
  // Forwarding data and readiness are not consulted in this build.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_data_ok, mem_data, wb_data};
`endif

  // rs1 operand select: x0, then MEM bypass, then WB bypass, then register file.
  always_comb begin
    rs1_val = rf_rs1_data;
    if (in_rs1 == '0)
      rs1_val = '0;
`ifdef OPERAND_FWD_EN
    else if (mem_we && (mem_rd == in_rs1) && mem_data_ok)
      rs1_val = mem_data;
    else if (wb_we && (wb_rd == in_rs1))
      rs1_val = wb_data;
`endif
  end

  // rs2 operand select: same priority as rs1.
  always_comb begin
    rs2_val = rf_rs2_data;
    if (in_rs2 == '0)
      rs2_val = '0;
`ifdef OPERAND_FWD_EN
    else if (mem_we && (mem_rd == in_rs2) && mem_data_ok)
      rs2_val = mem_data;
    else if (wb_we && (wb_rd == in_rs2))
      rs2_val = wb_data;
`endif
  end

  // rs1 conflict with an in-flight producer whose value cannot be supplied now.
  always_comb begin
    rs1_conflict = out_valid && out_mem_read && (out_rd == in_rs1);
`ifdef OPERAND_FWD_EN
    rs1_conflict = rs1_conflict ||
                   (mem_we && (mem_rd == in_rs1) && !mem_data_ok);
`else
    rs1_conflict = rs1_conflict ||
                   (out_valid && out_reg_write && (out_rd == in_rs1)) ||
                   (mem_we && (mem_rd == in_rs1)) ||
                   (wb_we && (wb_rd == in_rs1));
`endif
  end

  // rs2 conflict, same rules as rs1.
  always_comb begin
    rs2_conflict = out_valid && out_mem_read && (out_rd == in_rs2);
`ifdef OPERAND_FWD_EN
    rs2_conflict = rs2_conflict ||
                   (mem_we && (mem_rd == in_rs2) && !mem_data_ok);
`else
    rs2_conflict = rs2_conflict ||
                   (out_valid && out_reg_write && (out_rd == in_rs2)) ||
                   (mem_we && (mem_rd == in_rs2)) ||
                   (wb_we && (wb_rd == in_rs2));
`endif
  end

  // Stall only for sources the instruction really reads, never for x0.
  always_comb begin
    hazard = in_valid &&
             ((in_use_rs1 && (in_rs1 != '0) && rs1_conflict) ||
              (in_use_rs2 && (in_rs2 != '0) && rs2_conflict));
  end

  // Accept when the pipeline register is empty or being consumed this cycle.
  always_comb begin
    downstream_free = !out_valid || out_ready;
    in_ready        = !rst && !flush && !hazard && downstream_free;
    xfer            = in_valid && in_ready;
  end

  // ID/EX pipeline register: reset clears everything, flush kills the entry,
  // transfer loads a new instruction, consumption without refill leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_ctrl      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_imm       <= in_imm;
      out_rs1_val   <= rs1_val;
      out_rs2_val   <= rs2_val;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
      out_mem_read  <= in_mem_read;
      out_ctrl      <= in_ctrl;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the stage. Follows OPERAND_FWD_EN like the design.
module tb_id_ex_operand_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [XLEN-1:0]   in_pc, in_imm;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_use_rs1, in_use_rs2, in_reg_write, in_mem_read;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        rf_rs1, rf_rs2;
  logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
  logic [4:0]        mem_rd;
  logic              mem_we, mem_data_ok;
  logic [XLEN-1:0]   mem_data;
  logic [4:0]        wb_rd;
  logic              wb_we;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [4:0]        out_rd;
  logic              out_reg_write, out_mem_read;
  logic [CTRL_W-1:0] out_ctrl;

  id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_data_ok(mem_data_ok), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the pipeline register contents.
  logic              m_valid;
  logic [XLEN-1:0]   m_pc, m_imm, m_v1, m_v2;
  logic [4:0]        m_rd;
  logic              m_rw, m_mr;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_all;      // data fields are defined (all zero after reset)
  logic              pre_ready;  // in_ready seen in the last stepped cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value the instruction must receive for source s.
  function automatic logic [XLEN-1:0] m_sel(input logic [4:0] s, input logic [XLEN-1:0] rf);
    if (s == 5'd0) return '0;
`ifdef OPERAND_FWD_EN
    if (mem_we && mem_rd == s && mem_data_ok) return mem_data;
    if (wb_we && wb_rd == s) return wb_data;
`endif
    return rf;
  endfunction

  // Source s cannot be supplied this cycle.
  function automatic logic m_blocked(input logic [4:0] s);
    logic b;
    b = m_valid && m_mr && m_rd == s;
`ifdef OPERAND_FWD_EN
    b = b || (mem_we && mem_rd == s && !mem_data_ok);
`else
    b = b || (m_valid && m_rw && m_rd == s) || (mem_we && mem_rd == s) || (wb_we && wb_rd == s);
`endif
    return b;
  endfunction

  function automatic logic m_ready();
    logic hz;
    hz = in_valid && ((in_use_rs1 && in_rs1 != 5'd0 && m_blocked(in_rs1)) ||
                      (in_use_rs2 && in_rs2 != 5'd0 && m_blocked(in_rs2)));
    return !rst && !flush && !hz && (!m_valid || out_ready);
  endfunction

  // One clock: check combinational outputs, advance model, check registers.
  task automatic step();
    logic er;
    logic [XLEN-1:0] e1, e2;
    #1;
    er = m_ready();
    e1 = m_sel(in_rs1, rf_rs1_data);
    e2 = m_sel(in_rs2, rf_rs2_data);
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    chk("rf_rs1", {27'd0, rf_rs1}, {27'd0, in_rs1});
    chk("rf_rs2", {27'd0, rf_rs2}, {27'd0, in_rs2});
    pre_ready = in_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_pc = '0; m_imm = '0; m_v1 = '0; m_v2 = '0;
      m_rd = '0; m_rw = 0; m_mr = 0; m_ctrl = '0; m_all = 1;
    end else if (flush) begin
      m_valid = 0;
    end else if (in_valid && er) begin
      m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_v1 = e1; m_v2 = e2;
      m_rd = in_rd; m_rw = in_reg_write; m_mr = in_mem_read; m_ctrl = in_ctrl; m_all = 0;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid || m_all) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_imm", out_imm, m_imm);
      chk("out_rs1_val", out_rs1_val, m_v1);
      chk("out_rs2_val", out_rs2_val, m_v2);
      chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, m_rw});
      chk("out_mem_read", {31'd0, out_mem_read}, {31'd0, m_mr});
      chk("out_ctrl", {16'd0, out_ctrl}, {16'd0, m_ctrl});
    end
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_use_rs1 = 0; in_use_rs2 = 0; in_reg_write = 0; in_mem_read = 0; in_ctrl = '0;
    rf_rs1_data = '0; rf_rs2_data = '0;
    mem_rd = '0; mem_we = 0; mem_data_ok = 0; mem_data = '0;
    wb_rd = '0; wb_we = 0; wb_data = '0;
  endtask

  initial begin
    m_valid = 0; m_all = 0; pre_ready = 0;
    m_pc = '0; m_imm = '0; m_v1 = '0; m_v2 = '0; m_rd = '0; m_rw = 0; m_mr = 0; m_ctrl = '0;
    idle();

    // Reset held for two cycles while an instruction is offered.
    rst = 1; in_valid = 1; in_pc = 32'h0000_0050; in_imm = 32'h77; in_rd = 5'd2; in_reg_write = 1;
    repeat (2) begin
      step();
      chk("lit_rst_ready", {31'd0, pre_ready}, 32'd0);
      chk("lit_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("lit_rst_pc", out_pc, 32'd0);
    end
    rst = 0; in_pc = 32'h0000_0100;
    step();
    chk("lit_first_xfer_valid", {31'd0, out_valid}, 32'd1);
    chk("lit_first_xfer_pc", out_pc, 32'h100);

    // WB bypass of rs1.
    idle();
    in_valid = 1; in_pc = 32'h104; in_rs1 = 5'd5; in_use_rs1 = 1; rf_rs1_data = 32'h11;
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step();
`ifdef OPERAND_FWD_EN
    chk("lit_wb_bypass", out_rs1_val, 32'hDEADBEEF);
`else
    chk("lit_wb_stall", {31'd0, pre_ready}, 32'd0);
`endif
    in_rs1 = 5'd0; wb_rd = 5'd0; rf_rs1_data = 32'h0;
    step();
    chk("lit_x0_val", out_rs1_val, 32'd0);
    chk("lit_x0_pc", out_pc, 32'h104);

    // MEM bypass wins over WB for the same register.
    idle();
    in_valid = 1; in_pc = 32'h108; in_rs2 = 5'd7; in_use_rs2 = 1; rf_rs2_data = 32'hC;
    mem_we = 1; mem_rd = 5'd7; mem_data_ok = 1; mem_data = 32'hA;
    wb_we = 1; wb_rd = 5'd7; wb_data = 32'hB;
    step();
`ifdef OPERAND_FWD_EN
    chk("lit_priority", out_rs2_val, 32'hA);
`else
    chk("lit_priority_stall", {31'd0, pre_ready}, 32'd0);
`endif

    // Load-use: lw x3 then add reading x3.
    idle();
    in_valid = 1; in_pc = 32'h300; in_rd = 5'd3; in_reg_write = 1; in_mem_read = 1;
    step();
    chk("lit_lw_mem_read", {31'd0, out_mem_read}, 32'd1);
    in_pc = 32'h304; in_rd = 5'd4; in_mem_read = 0; in_rs1 = 5'd3; in_use_rs1 = 1;
    rf_rs1_data = 32'h5555;
    step();
    chk("lit_lu_stall1", {31'd0, pre_ready}, 32'd0);
    chk("lit_lu_bubble1", {31'd0, out_valid}, 32'd0);
    mem_we = 1; mem_rd = 5'd3; mem_data_ok = 0;
    step();
    chk("lit_lu_stall2", {31'd0, pre_ready}, 32'd0);
    chk("lit_lu_bubble2", {31'd0, out_valid}, 32'd0);
    mem_we = 0; wb_we = 1; wb_rd = 5'd3; wb_data = 32'h1234;
    step();
`ifdef OPERAND_FWD_EN
    chk("lit_lu_go", {31'd0, pre_ready}, 32'd1);
`else
    chk("lit_lu_stall3", {31'd0, pre_ready}, 32'd0);
    wb_we = 0; rf_rs1_data = 32'h1234;
    step();
    chk("lit_lu_go", {31'd0, pre_ready}, 32'd1);
`endif
    chk("lit_lu_val", out_rs1_val, 32'h1234);
    chk("lit_lu_pc", out_pc, 32'h304);

    // Backpressure with toggling WB data, flush in the second cycle.
    idle();
    in_valid = 1; in_pc = 32'h400; in_rs1 = 5'd9;
    step();
    in_pc = 32'h404; out_ready = 0; wb_we = 1; wb_rd = 5'd9; wb_data = 32'hFFFF_0000;
    step();
    chk("lit_bp_ready", {31'd0, pre_ready}, 32'd0);
    chk("lit_bp_pc", out_pc, 32'h400);
    wb_data = 32'h0000_FFFF; flush = 1;
    step();
    chk("lit_flush_ready", {31'd0, pre_ready}, 32'd0);
    chk("lit_flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 0; wb_data = 32'h5A5A_5A5A;
    step();
    chk("lit_after_flush_pc", out_pc, 32'h404);

    // Reset during hold drops the held instruction.
    in_valid = 0; rst = 1;
    step();
    chk("lit_rst_hold_valid", {31'd0, out_valid}, 32'd0);

    // Randomized traffic over a small register set to provoke hazards.
    idle();
    for (int unsigned i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      out_ready    = ($urandom_range(0, 9) < 7);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_pc        = $urandom;
      in_imm       = $urandom;
      in_rs1       = 5'($urandom_range(0, 3));
      in_rs2       = 5'($urandom_range(0, 3));
      in_rd        = 5'($urandom_range(0, 3));
      in_use_rs1   = 1'($urandom);
      in_use_rs2   = 1'($urandom);
      in_reg_write = 1'($urandom);
      in_mem_read  = 1'($urandom);
      in_ctrl      = 16'($urandom);
      rf_rs1_data  = (in_rs1 == 5'd0) ? '0 : $urandom;
      rf_rs2_data  = (in_rs2 == 5'd0) ? '0 : $urandom;
      mem_we       = 1'($urandom);
      mem_rd       = 5'($urandom_range(0, 3));
      mem_data_ok  = 1'($urandom);
      mem_data     = $urandom;
      wb_we        = 1'($urandom);
      wb_rd        = 5'($urandom_range(0, 3));
      wb_data      = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
